// File: rtl/selftrigger_record_capture.sv
// selftrigger_record_capture: circular pre-trigger capture that emits timestamped fixed-length records on a valid/ready stream
module selftrigger_record_capture #(
    parameter int PRETRIG    = 64,
    parameter int RECORD_LEN = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        trigger,
    input  logic [15:0] din,
    input  logic [63:0] timestamp,
    output logic [15:0] dout,
    output logic        dout_valid,
    input  logic        dout_ready,
    output logic        dout_header,
    output logic        dout_last,
    output logic        busy,
    output logic [15:0] missed_count
);
    localparam int AW = $clog2(RECORD_LEN);
    localparam int CW = $clog2(RECORD_LEN + 1);
    localparam int NW = $clog2(RECORD_LEN + 5);
    localparam logic [CW-1:0] PRE = CW'(PRETRIG);
    localparam logic [CW-1:0] POST = CW'(RECORD_LEN - PRETRIG);
    localparam logic [NW-1:0] HDR = NW'(4);
    localparam logic [NW-1:0] LAST_NB = NW'(RECORD_LEN + 3);

    typedef enum logic [1:0] {FILL, ARMED, CAPTURE, READOUT} state_t;
    state_t state, state_next;

    logic [15:0]   ram [RECORD_LEN];
    logic [15:0]   rdata, hdr_word;
    logic [AW-1:0] wp, rd_ptr, ra;
    logic [CW-1:0] cnt, cnt_inc;
    logic [NW-1:0] nb;
    logic [63:0]   ts;
    logic          trigger_d, trig_edge, accept, reject, we, primed, xfer, done, ld;

    assign trig_edge = trigger & ~trigger_d;
    assign accept    = state == ARMED && trig_edge && enable;
    assign reject    = trig_edge && state != ARMED;
    assign we        = enable && state != READOUT;
    assign cnt_inc   = cnt + CW'(1);
    assign xfer      = dout_valid & dout_ready;
    assign done      = xfer & dout_last;
    // primed delays the first load by one cycle so rdata already holds ram[start]
    assign ld        = state == READOUT && primed && nb <= LAST_NB && (!dout_valid || dout_ready);
    assign ra        = (ld && nb >= HDR) ? rd_ptr + AW'(1) : rd_ptr;
    assign hdr_word  = nb[1:0] == 2'd0 ? ts[63:48] :
                       nb[1:0] == 2'd1 ? ts[47:32] :
                       nb[1:0] == 2'd2 ? ts[31:16] : ts[15:0];

    always_ff @(posedge clk) begin
        if (reset) state <= FILL;
        else state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            FILL:    if (enable && cnt_inc == PRE) state_next = ARMED;
            ARMED:   if (accept) state_next = POST == CW'(1) ? READOUT : CAPTURE;
            CAPTURE: if (enable && cnt_inc == POST) state_next = READOUT;
            READOUT: if (done) state_next = FILL;
        endcase
    end

    always_comb busy = state == CAPTURE || state == READOUT;

    always_ff @(posedge clk) begin
        if (we) ram[wp] <= din;
        rdata <= ram[ra];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            trigger_d    <= 1'b0;
            wp           <= '0;
            cnt          <= '0;
            missed_count <= '0;
            primed       <= 1'b0;
            nb           <= '0;
            dout         <= '0;
            dout_valid   <= 1'b0;
            dout_header  <= 1'b0;
            dout_last    <= 1'b0;
        end else begin
            trigger_d <= trigger;
            if (we) wp <= wp + AW'(1);
            if (accept) ts <= timestamp;
            rd_ptr <= accept ? wp - AW'(PRETRIG) : ra;
            cnt <= accept ? CW'(1) :
                   state_next != state ? '0 :
                   (enable && (state == FILL || state == CAPTURE)) ? cnt_inc : cnt;
            if (reject && missed_count != 16'hFFFF) missed_count <= missed_count + 16'd1;
            primed <= state == READOUT;
            nb <= state != READOUT ? '0 : ld ? nb + NW'(1) : nb;
            if (ld) begin
                dout        <= nb < HDR ? hdr_word : rdata;
                dout_valid  <= 1'b1;
                dout_header <= nb < HDR;
                dout_last   <= nb == LAST_NB;
            end else if (xfer) begin
                dout_valid  <= 1'b0;
                dout_header <= 1'b0;
                dout_last   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_selftrigger_record_capture.sv
// tb_selftrigger_record_capture: drives a default and a small (wrap-around) instance with shared stimulus,
// each checked beat-by-beat against a record-level reference model.
module tb_selftrigger_record_capture;
    logic        clk = 1'b0, reset = 1'b1, enable = 1'b0, trigger = 1'b0, dout_ready = 1'b1;
    logic [15:0] din = '0;
    logic [63:0] timestamp = '0;
    logic [15:0] dout [2];
    logic [15:0] missed [2];
    logic        dvalid [2], dhdr [2], dlast [2], busy [2];

    selftrigger_record_capture #(.PRETRIG(64), .RECORD_LEN(256)) dut0 (
        .clk(clk), .reset(reset), .enable(enable), .trigger(trigger), .din(din),
        .timestamp(timestamp), .dout(dout[0]), .dout_valid(dvalid[0]), .dout_ready(dout_ready),
        .dout_header(dhdr[0]), .dout_last(dlast[0]), .busy(busy[0]), .missed_count(missed[0]));
    selftrigger_record_capture #(.PRETRIG(4), .RECORD_LEN(16)) dut1 (
        .clk(clk), .reset(reset), .enable(enable), .trigger(trigger), .din(din),
        .timestamp(timestamp), .dout(dout[1]), .dout_valid(dvalid[1]), .dout_ready(dout_ready),
        .dout_header(dhdr[1]), .dout_last(dlast[1]), .busy(busy[1]), .missed_count(missed[1]));

    always #5 clk = ~clk;

    function automatic int pp(input int i); return i == 0 ? 64 : 4; endfunction
    function automatic int rr(input int i); return i == 0 ? 256 : 16; endfunction

    int nchk = 0, nerr = 0, si = 0, tc = 0;
    bit bp = 0;
    logic [15:0] stream [$];
    logic [17:0] expq [2][$];
    int m_mode [2], m_cnt [2], m_tpos [2], m_missed [2], lat [2], xcnt [2];
    logic [63:0] m_ts [2];
    bit stall [2];
    logic [17:0] held [2];
    logic tprev = 1'b0;

    task automatic chk(input string nm, input int i, input logic [63:0] got, input logic [63:0] want);
        nchk++;
        if (got !== want) begin
            nerr++;
            $display("FAIL %s dut%0d at %0t: got %0h expected %0h", nm, i, $time, got, want);
        end
    endtask

    task automatic cyc(input bit en, input bit tr);
        enable = en;
        trigger = tr;
        din = 16'(si);
        timestamp = 64'h0123_4567_89AB_0000 + 64'(tc);
        dout_ready = bp ? ($urandom_range(0, 99) < 30) : 1'b1;
        @(posedge clk);
        #1;
        tc++;
        if (en && !reset) si++;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        cyc(0, 0);
        reset = 1'b0;
        si = 0;
    endtask

    task automatic drain();
        for (int i = 0; i < 2; i++) chk("drain", i, 64'(expq[i].size()), 64'd0);
    endtask

    // Monitor and reference model: outputs seen here follow the last edge, inputs belong to the next edge.
    always @(negedge clk) begin
        if (reset) stream.delete();
        else if (enable) stream.push_back(din);
        for (int i = 0; i < 2; i++) begin
            bit xf, e;
            xf = dvalid[i] && dout_ready && !reset;
            e = trigger && !tprev;
            chk("busy", i, 64'(busy[i]), 64'(m_mode[i] >= 2));
            chk("missed", i, 64'(missed[i]), 64'(m_missed[i]));
            if (m_mode[i] != 3) chk("idle_valid", i, 64'(dvalid[i]), 64'd0);
            else if (lat[i] >= 0) begin
                chk("first_valid_latency", i, 64'(dvalid[i]), 64'(lat[i] == 2));
                lat[i] = lat[i] == 2 ? -1 : lat[i] + 1;
            end else chk("valid_hold", i, 64'(dvalid[i]), 64'd1);
            if (stall[i]) chk("stall_hold", i, 64'({dvalid[i], dhdr[i], dlast[i], dout[i]}), 64'({1'b1, held[i]}));
            stall[i] = dvalid[i] && !dout_ready && !reset;
            held[i] = {dhdr[i], dlast[i], dout[i]};
            if (xf) begin
                chk("beat_expected", i, 64'(expq[i].size() > 0), 64'd1);
                if (expq[i].size() > 0) chk("beat", i, 64'({dhdr[i], dlast[i], dout[i]}), 64'(expq[i].pop_front()));
                xcnt[i]++;
            end
            if (reset) begin
                m_mode[i] = 0;
                m_cnt[i] = 0;
                m_missed[i] = 0;
                lat[i] = -1;
                xcnt[i] = 0;
                expq[i].delete();
            end else begin
                if (e && m_mode[i] != 1 && m_missed[i] < 65535) m_missed[i]++;
                case (m_mode[i])
                    0: if (enable) begin
                        m_cnt[i]++;
                        if (m_cnt[i] == pp(i)) m_mode[i] = 1;
                    end
                    1: if (enable && e) begin
                        m_ts[i] = timestamp;
                        m_tpos[i] = stream.size() - 1;
                        m_mode[i] = 2;
                    end
                    3: if (xf && expq[i].size() == 0) begin
                        m_mode[i] = 0;
                        m_cnt[i] = 0;
                    end
                    default: ;
                endcase
                if (m_mode[i] == 2 && enable && stream.size() - m_tpos[i] == rr(i) - pp(i)) begin
                    for (int k = 0; k < 4; k++) expq[i].push_back({1'b1, 1'b0, 16'(m_ts[i] >> (48 - 16 * k))});
                    for (int k = 0; k < rr(i); k++)
                        expq[i].push_back({1'b0, k == rr(i) - 1, stream[m_tpos[i] - pp(i) + k]});
                    m_mode[i] = 3;
                    lat[i] = 0;
                end
            end
        end
        tprev = reset ? 1'b0 : trigger;
    end

    initial begin
        bit done10;
        cyc(0, 0);
        cyc(0, 0);
        reset = 1'b0;
        si = 0;
        for (int i = 0; i < 2; i++) begin
            chk("rst_dout", i, 64'(dout[i]), 64'd0);
            chk("rst_header", i, 64'(dhdr[i]), 64'd0);
            chk("rst_last", i, 64'(dlast[i]), 64'd0);
            chk("rst_valid", i, 64'(dvalid[i]), 64'd0);
        end
        // basic record
        apply_reset();
        for (int k = 0; k < 700; k++) cyc(1, si == 100);
        drain();
        // early trigger, then a valid one
        apply_reset();
        for (int k = 0; k < 800; k++) cyc(1, si == 10 || si == 200);
        drain();
        // back-pressure
        apply_reset();
        bp = 1;
        for (int k = 0; k < 1600; k++) cyc(1, si == 100);
        bp = 0;
        for (int k = 0; k < 10; k++) cyc(1, 0);
        drain();
        // held trigger plus extra edges
        apply_reset();
        for (int k = 0; k < 800; k++) cyc(1, (si >= 100 && si < 150) || si == 200 || si == 400 || si == 500);
        drain();
        // enable gaps
        apply_reset();
        for (int k = 0; k < 1400; k++) begin
            bit en;
            en = 1'($urandom_range(0, 1));
            cyc(en, en && si == 100);
        end
        drain();
        // reset mid-readout
        apply_reset();
        for (int k = 0; k < 3000 && xcnt[0] < 20; k++) cyc(1, si == 100);
        chk("beat20_reached", 0, 64'(xcnt[0] >= 20), 64'd1);
        apply_reset();
        chk("midrst_valid", 0, 64'(dvalid[0]), 64'd0);
        chk("midrst_busy", 0, 64'(busy[0]), 64'd0);
        chk("midrst_missed", 0, 64'(missed[0]), 64'd0);
        for (int k = 0; k < 700; k++) cyc(1, si == 63 || si == 65);
        drain();
        // wrap-around on the small instance, plus an ignored edge with enable low while armed
        apply_reset();
        done10 = 0;
        for (int k = 0; k < 300; k++) begin
            if (si == 10 && !done10) begin
                cyc(0, 1);
                done10 = 1;
            end else cyc(1, si == 18);
        end
        drain();
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule

// File: doc/selftrigger_record_capture.md
# selftrigger_record_capture

Downstream consumer of the filtered self-trigger stage. It keeps a circular pre-trigger history of the 16-bit sample stream and starts a fixed-length record on each rising edge of `trigger`. Each record is a 4-word timestamp header followed by RECORD_LEN samples, emitted over a valid/ready stream. Triggers that arrive while the block cannot accept them are counted, not queued.

## Interface

Parameters:
- PRETRIG, 64: number of samples in a record that come before the trigger sample; must be at least 1 and less than RECORD_LEN.
- RECORD_LEN, 256: total samples per record; power of 2, 16..1024; also the ring depth.

Ports:
- clk  in  1  sample clock.
- reset  in  1  synchronous, active-high.
- enable  in  1  sample strobe; sample writes and capture counting advance only when high.
- trigger  in  1  self-trigger level from the upstream filter; the rising edge is used.
- din  in  16  signed sample, cycle-aligned with trigger.
- timestamp  in  64  free-running timestamp, latched at the trigger edge.
- dout  out  16  stream data.
- dout_valid  out  1  stream valid.
- dout_ready  in  1  stream ready from the consumer.
- dout_header  out  1  high on the 4 header beats.
- dout_last  out  1  high on the final sample beat.
- busy  out  1  high in CAPTURE and READOUT.
- missed_count  out  16  saturating count of rejected trigger edges.

## Operation

- Ring RAM: RECORD_LEN x 16, with write pointer wp.
  - When enable=1 in FILL, ARMED or CAPTURE: ram[wp] <= din, then wp <= wp+1 (mod RECORD_LEN).
- Edge detect: trig_edge = trigger & ~trigger_d. trigger_d updates every cycle and clears on reset.
- States:
  - FILL (reset state)
    - Count enabled writes.
    - After PRETRIG writes, go to ARMED.
    - trig_edge in FILL is rejected.
  - ARMED
    - On trig_edge with enable=1:
      - Latch ts <= timestamp.
      - Set start <= wp - PRETRIG (mod RECORD_LEN).
      - The current din is written as the first post-trigger sample; post count = 1.
      - Go to CAPTURE.
    - If trig_edge occurs with enable=0, it is ignored and not counted.
  - CAPTURE
    - Count enabled writes until post count = RECORD_LEN-PRETRIG.
    - Then go to READOUT.
    - trig_edge is rejected.
  - READOUT
    - No RAM writes.
    - Beats 0..3: ts[63:48], ts[47:32], ts[31:16], ts[15:0] with dout_header=1.
    - Beats 4..RECORD_LEN+3: ram[start+k], k = 0..RECORD_LEN-1 (mod RECORD_LEN).
    - dout_last=1 on the final beat.
    - After the final beat is accepted, go to FILL with the fill count cleared, so PRETRIG fresh samples are required before rearming.
    - trig_edge is rejected. READOUT ignores enable.
- Rejected edges: missed_count <= missed_count+1, saturating at 16'hFFFF.
- Handshake: a beat transfers when dout_valid & dout_ready.
  - While dout_valid=1 and dout_ready=0, dout, dout_header and dout_last hold stable.
  - dout_valid never drops without a transfer, except on reset.
  - The RAM read is prefetched one beat ahead so that back-to-back transfers are possible.
- Simultaneous events:
  - trig_edge in the cycle CAPTURE completes: rejected and counted.
  - trig_edge in the cycle the final beat is accepted: rejected and counted.
- Reset in any state, effective next edge:
  - State returns to FILL; counters and wp clear.
  - RAM contents are not cleared; they are don't-care.
  - Any in-flight record is discarded without dout_last.

## Timing

- Reset values: dout=0, dout_valid=0, dout_header=0, dout_last=0, busy=0, missed_count=0.
- Sample and trigger inputs are used in the same cycle; there is no internal input register stage.
- busy rises on the clock edge that samples the accepted trig_edge.
- The first header beat has dout_valid=1 exactly 2 cycles after the edge that writes the last post-trigger sample.
- With dout_ready held at 1: RECORD_LEN+4 consecutive valid beats, no bubbles.
- busy falls on the edge that accepts the dout_last beat.
- Minimum trigger-to-trigger spacing: (RECORD_LEN-PRETRIG) + 2 + (RECORD_LEN+4) + PRETRIG cycles, assuming enable and dout_ready are held high.

## Test plan

- **Basic record.** Defaults; enable=1; din = sample index from 0 after reset; timestamp = cycle count. Single 1-cycle trigger at sample 100.
  - Expect 260 beats: header = timestamp at sample 100, then samples 36..291.
  - dout_last only on sample 291; missed_count=0.
- **Early trigger.** Trigger at sample 10, while still in FILL.
  - Expect no record; missed_count=1.
  - A later trigger at sample 200 yields samples 136..391.
- **Back-pressure.** Same as the basic record, with dout_ready toggled randomly at a 30% duty cycle.
  - Expect an identical beat sequence.
  - Data holds stable while stalled; no beat is dropped or duplicated.
- **Held and extra edges.** Trigger held high for 50 cycles, followed by 3 extra edges during CAPTURE/READOUT.
  - Expect exactly one record; missed_count=3.
- **Enable gaps.** enable at a 50% duty cycle; din increments only on enabled cycles.
  - Record content is identical to the basic-record case, in sample index terms.
  - READOUT beat timing is unaffected by the enable gaps.
- **Reset mid-readout.** reset pulsed for 1 cycle at beat 20 of a record.
  - Next cycle: dout_valid=0, busy=0, missed_count=0.
  - A new trigger is accepted only after 64 new samples.
- **Wrap-around.** PRETRIG=4, RECORD_LEN=16; trigger at sample 18 (wp=2).
  - Expect samples 14..29 in order, crossing the ring boundary correctly.
